// File: rtl/rng_pkg.sv
// Purpose: shared types, LFSR taps and constants for the RNG scheduler slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rng_pkg;

    typedef enum logic [1:0] {
        SEED_REQ  = 2'd0,
        SEED_WAIT = 2'd1,
        SERVE     = 2'd2
    } state_t;

    // XNOR feedback taps of the 16-bit LFSR
    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    // With XNOR feedback the all-ones word maps onto itself forever
    localparam logic [15:0] LOCKUP                = 16'hFFFF;
    localparam logic [15:0] DEFAULT_SEED_ADDR     = 16'h07FE;
    localparam logic [15:0] DEFAULT_FALLBACK_SEED = 16'h0005;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ~(q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D])};
    endfunction

endpackage

// File: rtl/rng_scheduler_lfsr.sv
// Purpose: 16-bit XNOR LFSR with parallel load; load wins over step.
// Latency: new value visible one cycle after load/step.
// Backpressure: none; holds its value when neither load nor step is asserted.
//
// Ports: clock, nrst (async active-low), load + load_val (seed), step (advance once), q (state).
module lfsr16_xnor
    import rng_pkg::*;
#(
    parameter logic [15:0] FALLBACK_SEED = DEFAULT_FALLBACK_SEED
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            q <= FALLBACK_SEED;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/rng_scheduler.sv
// Purpose: fetches the RNG seed from memory, then shares one LFSR among NREQ requesters round-robin.
// Latency: grant/rand_data registered, one cycle after the winning req is sampled; seed fetch MEM_LATENCY+1 cycles.
// Backpressure: none; at most one grant per cycle, requests ignored while not ready, level req is the only queue.
//
// Ports:
//   clock, nrst          - clock and async active-low reset
//   reseed               - one-cycle pulse restarting the seed fetch
//   mem_data_out         - memory read data (seed word)
//   mem_addr/mem_rd/mem_sel - memory address, read strobe, port ownership (1 while fetching)
//   req/grant            - level requests in, one-hot single-cycle grant out
//   rand_valid/rand_data/rand_data_4bit - random word for the granted requester
//   ready                - seeded and serving
module rng_scheduler
    import rng_pkg::*;
#(
    parameter int          NREQ          = 4,
    parameter logic [15:0] SEED_ADDR     = DEFAULT_SEED_ADDR,
    parameter int          MEM_LATENCY   = 1,
    parameter logic [15:0] FALLBACK_SEED = DEFAULT_FALLBACK_SEED
) (
    input  logic            clock,
    input  logic            nrst,
    input  logic            reseed,
    input  logic [15:0]     mem_data_out,
    output logic [15:0]     mem_addr,
    output logic            mem_rd,
    output logic            mem_sel,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            rand_valid,
    output logic [15:0]     rand_data,
    output logic [15:0]     rand_data_4bit,
    output logic            ready
);

    localparam int              PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]      WAIT_INIT = 2'(MEM_LATENCY - 1);
    localparam logic [NREQ-1:0] ONE       = NREQ'(1);

    state_t          state;
    logic [1:0]      wait_cnt;
    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] last_grant;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] pick;
    logic            win_vld;
    logic [PW-1:0]   winner;
    logic [NREQ-1:0] win_onehot;
    logic [PW-1:0]   ptr_next;

    logic            lfsr_load;
    logic            lfsr_step;
    logic [15:0]     lfsr_q;
    logic [15:0]     seed_val;

    // Round-robin: prefer eligible requesters at or above the pointer, else wrap
    // to the lowest eligible one. Masking with last_grant stops a requester that
    // has not yet dropped req from being served twice in a row.
    always_comb begin
        eligible = req & ~last_grant;
        hi_mask  = ~((ONE << ptr) - ONE);
        pick     = ((eligible & hi_mask) != '0) ? (eligible & hi_mask) : eligible;
        win_vld  = (pick != '0);
        winner   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                winner = PW'(i);
            end
        end
        win_onehot = win_vld ? (ONE << winner) : '0;
        ptr_next   = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

    assign seed_val  = (mem_data_out == LOCKUP) ? FALLBACK_SEED : mem_data_out;
    assign lfsr_load = (state == SEED_WAIT) && !reseed && (wait_cnt == 2'd0);
    // reseed takes priority over a same-cycle grant, so the LFSR must not move either
    assign lfsr_step = (state == SERVE) && !reseed && win_vld;

    lfsr16_xnor #(
        .FALLBACK_SEED(FALLBACK_SEED)
    ) u_lfsr (
        .clock   (clock),
        .nrst    (nrst),
        .load    (lfsr_load),
        .load_val(seed_val),
        .step    (lfsr_step),
        .q       (lfsr_q)
    );

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state      <= SEED_REQ;
            wait_cnt   <= 2'd0;
            mem_sel    <= 1'b1;
            mem_rd     <= 1'b0;
            mem_addr   <= SEED_ADDR;
            grant      <= '0;
            rand_valid <= 1'b0;
            rand_data  <= 16'h0000;
            ready      <= 1'b0;
            ptr        <= '0;
            last_grant <= '0;
        end else begin
            mem_addr   <= SEED_ADDR;
            mem_rd     <= 1'b0;
            grant      <= '0;
            rand_valid <= 1'b0;
            last_grant <= '0;
            case (state)
                SEED_REQ: begin
                    if (!reseed) begin
                        mem_rd   <= 1'b1;
                        wait_cnt <= WAIT_INIT;
                        state    <= SEED_WAIT;
                    end
                end
                SEED_WAIT: begin
                    if (reseed) begin
                        state <= SEED_REQ;
                    end else if (wait_cnt == 2'd0) begin
                        state   <= SERVE;
                        ready   <= 1'b1;
                        mem_sel <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                SERVE: begin
                    if (reseed) begin
                        state   <= SEED_REQ;
                        ready   <= 1'b0;
                        mem_sel <= 1'b1;
                    end else if (win_vld) begin
                        grant      <= win_onehot;
                        rand_valid <= 1'b1;
                        rand_data  <= lfsr_q;
                        ptr        <= ptr_next;
                        last_grant <= win_onehot;
                    end
                end
                default: begin
                    state   <= SEED_REQ;
                    ready   <= 1'b0;
                    mem_sel <= 1'b1;
                end
            endcase
        end
    end

    assign rand_data_4bit = {12'd0, rand_data[3:0]};

endmodule
